// File: rtl/switch_button_reader.sv
// rtl/switch_button_reader.sv - synchronized, debounced switch/button reader with sticky press bits (optional BTN_IRQ_EN)
module switch_button_reader #(
    parameter int unsigned FREQ  = 100,
    parameter int unsigned SW_W  = 24,
    parameter int unsigned BTN_W = 5
) (
    input  logic             dig_clk,
    input  logic             dig_rst,
    input  logic [31:0]      dig_addr,
    input  logic             dig_re,
    input  logic             dig_we,
    input  logic [31:0]      dig_wdata,
    output logic [31:0]      dig_rdata,
    output logic             dig_rvalid,
    input  logic [SW_W-1:0]  sw_in,
    input  logic [BTN_W-1:0] btn_in,
    output logic             irq
);

    localparam int unsigned IN_W   = SW_W + BTN_W;
    localparam logic [15:0] RELOAD = 16'(FREQ);

    logic [15:0]      tick_cnt;
    logic             tick;
    logic [IN_W-1:0]  sync1, sync2, hist0, hist1, level, level_next;
    logic [BTN_W-1:0] btn_lvl, btn_next, pend, pend_next, clr;
    logic [31:0]      rd_mux;
    logic             unused;

`ifdef BTN_IRQ_EN
    logic [BTN_W-1:0] mask;
`endif

    assign unused = ^{dig_addr[31:4], dig_addr[1:0], dig_wdata};
    assign tick   = (tick_cnt == 16'd0);

    // Switches and buttons share one synchronizer/debounce path: buttons occupy the top BTN_W bits.
    always_comb begin
        level_next = level;
        if (tick)
            level_next = (sync2 & hist0 & hist1) | (level & (sync2 | hist0 | hist1));
    end

    assign btn_lvl  = level[IN_W-1:SW_W];
    assign btn_next = level_next[IN_W-1:SW_W];
    assign clr      = (dig_we && dig_addr[3:2] == 2'd2) ? dig_wdata[BTN_W-1:0] : '0;
    // A rising edge in the same cycle as a clear keeps the bit set.
    assign pend_next = (pend & ~clr) | (btn_next & ~btn_lvl);

    always_comb begin
        rd_mux = '0;
        case (dig_addr[3:2])
            2'd0: rd_mux = 32'(level[SW_W-1:0]);
            2'd1: rd_mux = 32'(btn_lvl);
            2'd2: rd_mux = 32'(pend);
`ifdef BTN_IRQ_EN
            2'd3: rd_mux = 32'(mask);
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge dig_clk or posedge dig_rst) begin
        if (dig_rst) begin
            tick_cnt   <= RELOAD;
            sync1      <= '0;
            sync2      <= '0;
            hist0      <= '0;
            hist1      <= '0;
            level      <= '0;
            pend       <= '0;
            dig_rdata  <= '0;
            dig_rvalid <= 1'b0;
        end else begin
            tick_cnt <= tick ? RELOAD : tick_cnt - 16'd1;
            sync1    <= {btn_in, sw_in};
            sync2    <= sync1;
            if (tick) begin
                hist0 <= sync2;
                hist1 <= hist0;
            end
            level      <= level_next;
            pend       <= pend_next;
            dig_rvalid <= dig_re;
            if (dig_re)
                dig_rdata <= rd_mux;
        end
    end

`ifdef BTN_IRQ_EN
    always_ff @(posedge dig_clk or posedge dig_rst) begin
        if (dig_rst) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (dig_we && dig_addr[3:2] == 2'd3)
                mask <= dig_wdata[BTN_W-1:0];
            irq <= |(pend & mask);
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_switch_button_reader.sv
// tb/tb_switch_button_reader.sv - directed self-checking bench for switch_button_reader (FREQ=3)
module tb_switch_button_reader;

    logic        dig_clk = 1'b0;
    logic        dig_rst = 1'b1;
    logic [31:0] dig_addr = '0;
    logic        dig_re = 1'b0;
    logic        dig_we = 1'b0;
    logic [31:0] dig_wdata = '0;
    logic [31:0] dig_rdata;
    logic        dig_rvalid;
    logic [23:0] sw_in = '0;
    logic [4:0]  btn_in = '0;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int c0;

`ifdef BTN_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    switch_button_reader #(.FREQ(3), .SW_W(24), .BTN_W(5)) dut (
        .dig_clk(dig_clk), .dig_rst(dig_rst), .dig_addr(dig_addr), .dig_re(dig_re),
        .dig_we(dig_we), .dig_wdata(dig_wdata), .dig_rdata(dig_rdata),
        .dig_rvalid(dig_rvalid), .sw_in(sw_in), .btn_in(btn_in), .irq(irq)
    );

    always #5 dig_clk = ~dig_clk;

    // Posedges since reset release; with FREQ=3 the debounce tick lands on every 4th one.
    always @(posedge dig_clk or posedge dig_rst)
        if (dig_rst) cyc <= 0;
        else         cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        dig_addr = addr;
        dig_re   = 1'b1;
        @(negedge dig_clk);
        dig_re = 1'b0;
        check({tag, " rvalid"}, 32'(dig_rvalid), 32'd1);
        check(tag, dig_rdata, exp);
        @(negedge dig_clk);
        check({tag, " rvalid pulse"}, 32'(dig_rvalid), 32'd0);
        check({tag, " hold"}, dig_rdata, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        dig_addr  = addr;
        dig_wdata = data;
        dig_we    = 1'b1;
        @(negedge dig_clk);
        dig_we = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge dig_clk);
    endtask

    task automatic align4();
        while (cyc % 4 != 0) @(negedge dig_clk);
    endtask

    initial begin
        #12;
        check("reset rdata", dig_rdata, 32'd0);
        check("reset rvalid", 32'(dig_rvalid), 32'd0);
        check("reset irq", 32'(irq), 32'd0);
        @(negedge dig_clk);
        dig_rst = 1'b0;

        // back-to-back reads of all four offsets
        for (int i = 0; i < 4; i++) begin
            dig_addr = 32'(i * 4);
            dig_re   = 1'b1;
            @(negedge dig_clk);
            check("b2b rvalid", 32'(dig_rvalid), 32'd1);
            check("b2b rdata", dig_rdata, 32'd0);
        end
        dig_re = 1'b0;
        @(negedge dig_clk);
        check("b2b rvalid end", 32'(dig_rvalid), 32'd0);

        // switches: zero before the lag, settled by the 14th edge
        sw_in = 24'hA5A5A5;
        rd("sw early", 32'h0, 32'h0);
        cycles(11);
        rd("sw settled", 32'h0, 32'h00A5A5A5);

        // two-cycle glitch on btn 2
        btn_in[2] = 1'b1;
        cycles(2);
        btn_in[2] = 1'b0;
        cycles(20);
        rd("glitch btn", 32'h4, 32'h0);
        rd("glitch pend", 32'h8, 32'h0);

        // btn 0 press, W1C alongside a read, hold, re-press
        btn_in[0] = 1'b1;
        cycles(40);
        rd("btn0 level", 32'h4, 32'h1);
        rd("btn0 pend", 32'h8, 32'h1);
        dig_addr = 32'h8; dig_wdata = 32'h1; dig_re = 1'b1; dig_we = 1'b1;
        @(negedge dig_clk);
        dig_re = 1'b0; dig_we = 1'b0;
        check("rw rvalid", 32'(dig_rvalid), 32'd1);
        check("rw pre-write", dig_rdata, 32'h1);
        rd("pend cleared", 32'h8, 32'h0);
        cycles(20);
        rd("pend held btn", 32'h8, 32'h0);
        btn_in[0] = 1'b0;
        cycles(20);
        rd("btn0 released", 32'h4, 32'h0);
        btn_in[0] = 1'b1;
        cycles(20);
        rd("btn0 repress", 32'h8, 32'h1);
        wr(32'h8, 32'h1);
        btn_in[0] = 1'b0;
        cycles(20);

        // W1C landing on the exact debounced rise of btn 1 (tick edges at 4k; rise at c0+12)
        align4();
        c0 = cyc;
        btn_in[1] = 1'b1;
        while (cyc != c0 + 11) @(negedge dig_clk);
        wr(32'h8, 32'h2);
        rd("set wins", 32'h8, 32'h2);
        wr(32'h8, 32'h2);
        rd("pend1 cleared", 32'h8, 32'h0);
        btn_in[1] = 1'b0;
        cycles(20);

        // irq path
        wr(32'hC, 32'h2);
        rd("mask", 32'hC, IRQ_ON ? 32'h2 : 32'h0);
        check("irq idle", 32'(irq), 32'd0);
        align4();
        c0 = cyc;
        btn_in[1] = 1'b1;
        while (cyc != c0 + 12) @(negedge dig_clk);
        check("irq same cycle as pend", 32'(irq), 32'd0);
        @(negedge dig_clk);
        check("irq after pend", 32'(irq), 32'(IRQ_ON));
        wr(32'h8, 32'h2);
        check("irq at clear", 32'(irq), 32'(IRQ_ON));
        @(negedge dig_clk);
        check("irq after clear", 32'(irq), 32'd0);
        btn_in[0] = 1'b1;
        cycles(20);
        rd("btn0 masked pend", 32'h8, 32'h1);
        check("irq masked btn", 32'(irq), 32'd0);

        // reset with a read just issued
        dig_addr = 32'h0;
        dig_re   = 1'b1;
        #3 dig_rst = 1'b1;
        dig_re = 1'b0;
        @(negedge dig_clk);
        check("rst rvalid", 32'(dig_rvalid), 32'd0);
        check("rst rdata", dig_rdata, 32'd0);
        check("rst irq", 32'(irq), 32'd0);
        dig_rst = 1'b0;
        rd("sw after rst", 32'h0, 32'h0);
        rd("pend after rst", 32'h8, 32'h0);
        rd("mask after rst", 32'hC, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
